// File: rtl/seg_pattern_decoder_pkg.sv
// Package seg_pkg: shared definitions for the seven-segment pattern decoder.
//   - segment bit masks SEG_A..SEG_G, SEG_DP ({dp,G,F,E,D,C,B,A}, bit0 = A)
//   - the 16 hex glyphs (active-high segment patterns, index = nibble)
//   - seg2hex(): 7-bit glyph -> {ok, nibble}
//   - decoder FSM state type and the LUT result struct
package seg_pkg;

  localparam logic [7:0] SEG_A  = 8'h01;
  localparam logic [7:0] SEG_B  = 8'h02;
  localparam logic [7:0] SEG_C  = 8'h04;
  localparam logic [7:0] SEG_D  = 8'h08;
  localparam logic [7:0] SEG_E  = 8'h10;
  localparam logic [7:0] SEG_F  = 8'h20;
  localparam logic [7:0] SEG_G  = 8'h40;
  localparam logic [7:0] SEG_DP = 8'h80;

  // Ascending range so GLYPHS[n] is the pattern for nibble n.
  localparam logic [0:15][6:0] GLYPHS = {
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    ST_SETTLE,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic       ok;      // pattern is a legal glyph
    logic       blank;   // no segment lit
    logic [3:0] nibble;  // decoded value, meaningful only when ok
  } glyph_t;

  // Returns {1'b1, nibble} for a glyph in the table, 5'b0 otherwise.
  function automatic logic [4:0] seg2hex(input logic [6:0] y);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (y == GLYPHS[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_pattern_decoder_if.sv
// Interface seg_pattern_decoder_if: the snooped display bus plus the decoded view.
//   seg_n   [7:0]        active-low segments {dp,G,F,E,D,C,B,A}
//   dig_n   [DIGITS-1:0] active-low digit selects
//   hex     [4*DIGITS-1:0] decoded nibble per digit, digit k at [4k+3:4k]
//   dp, vld, err [DIGITS-1:0] per-digit decimal point / legal / illegal flags
//   upd                  one-cycle pulse per commit
//   upd_idx [IW-1:0]     digit index of that commit
// Modports: master drives the display bus and observes results; slave is the decoder.
interface seg_pattern_decoder_if #(
  parameter int DIGITS = 4
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [7:0]          seg_n;
  logic [DIGITS-1:0]   dig_n;
  logic [4*DIGITS-1:0] hex;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   vld;
  logic [DIGITS-1:0]   err;
  logic                upd;
  logic [IW-1:0]       upd_idx;

  modport master (
    output seg_n, dig_n,
    input  hex, dp, vld, err, upd, upd_idx
  );

  modport slave (
    input  seg_n, dig_n,
    output hex, dp, vld, err, upd, upd_idx
  );

endinterface

// File: rtl/seg_pattern_decoder_glyph_lut.sv
// Module seg_glyph_lut: combinational 7-segment pattern -> {ok, blank, nibble}.
//   y  in  7        active-high segments {G,F,E,D,C,B,A}
//   g  out glyph_t  lookup result
// Build option SEG_DECODE_ALT_GLYPH_EN: also accept the alternate glyphs
//   7 drawn with segment F (0x27) and 9 drawn without segment D (0x67).
module seg_glyph_lut
  import seg_pkg::*;
(
  input  logic [6:0] y,
  output glyph_t     g
);

`ifdef SEG_DECODE_ALT_GLYPH_EN
  localparam logic [6:0] ALT_SEVEN = GLYPHS[7] | SEG_F[6:0];
  localparam logic [6:0] ALT_NINE  = GLYPHS[9] & ~SEG_D[6:0];
`endif

  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch.
    g        = '0;
    {g.ok, g.nibble} = seg2hex(y);
    g.blank  = (y == 7'h00);
`ifdef SEG_DECODE_ALT_GLYPH_EN
    if (y == ALT_SEVEN) begin
      g.ok     = 1'b1;
      g.nibble = 4'h7;
    end
    if (y == ALT_NINE) begin
      g.ok     = 1'b1;
      g.nibble = 4'h9;
    end
`endif
  end

endmodule

// File: rtl/seg_pattern_decoder.sv
// Module seg_pattern_decoder: recovers hex digits from a multiplexed, common-anode
// seven-segment bus. The segment/digit lines are synchronised, debounced over
// STABLE_CYCLES identical samples, and each stable glyph is committed to the
// registers of the single selected digit.
//   clk   in  1  clock
//   rst   in  1  asynchronous, active-high reset
//   bus   seg_pattern_decoder_if.slave (seg_n, dig_n in; hex, dp, vld, err, upd, upd_idx out)
// Parameters: DIGITS (>=1), STABLE_CYCLES (>=1).
// Build option SEG_DECODE_ALT_GLYPH_EN (tested only inside seg_glyph_lut) accepts
// the alternate 7 and 9 glyphs.
module seg_pattern_decoder
  import seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst,
  seg_pattern_decoder_if.slave bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int SW = 8 + DIGITS;

  // Synchroniser: s1 -> s2 is the 2-flop sync, s3 is the previous s2.
  logic [SW-1:0] s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // All-ones is the idle (nothing lit, no digit selected) bus state.
      s1 <= '1;
      s2 <= '1;
      s3 <= '1;
    end else begin
      // NOTE: non-blocking so each stage captures the value from before the edge.
      s1 <= {bus.seg_n, bus.dig_n};
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Decode of the synchronised sample.
  logic [7:0]        seg;
  logic [DIGITS-1:0] dig_sel;
  logic [6:0]        y;
  logic              sel_ok;
  logic [IW-1:0]     sel_idx;
  glyph_t            g;

  assign seg     = s2[SW-1:DIGITS];
  assign dig_sel = ~s2[DIGITS-1:0];
  assign y       = ~seg[6:0];
  assign sel_ok  = $onehot(dig_sel);

  always_comb begin
    sel_idx = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig_sel[k]) sel_idx = IW'(k);
    end
  end

  seg_glyph_lut u_lut (
    .y (y),
    .g (g)
  );

  // Stability counter: saturates at STABLE_CYCLES instead of wrapping.
  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          stable;

  assign stable  = (s2 == s3);
  assign cnt_inc = (cnt == CW'(STABLE_CYCLES)) ? cnt : cnt + 1'b1;

  // Per-digit result registers and the commit strobe.
  logic [DIGITS-1:0][3:0] hex_q;
  logic [DIGITS-1:0]      dp_q;
  logic [DIGITS-1:0]      vld_q;
  logic [DIGITS-1:0]      err_q;
  logic                   upd_q;
  logic [IW-1:0]          upd_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_SETTLE;
      cnt       <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
      // NOTE: the per-digit registers are ordinary flops, not a RAM, so they reset too.
      hex_q     <= '0;
      dp_q      <= '0;
      vld_q     <= '0;
      err_q     <= '0;
    end else begin
      upd_q <= 1'b0;
      case (state)
        ST_SETTLE: begin
          if (!stable) begin
            cnt <= '0;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CW'(STABLE_CYCLES)) begin
              state <= ST_HOLD;
              // Ambiguous digit selection still ends the window, but writes nothing.
              if (sel_ok) begin
                upd_q     <= 1'b1;
                upd_idx_q <= sel_idx;
                if (g.ok) begin
                  hex_q[sel_idx] <= g.nibble;
                  dp_q[sel_idx]  <= ~seg[7];
                  vld_q[sel_idx] <= 1'b1;
                  err_q[sel_idx] <= 1'b0;
                end else if (g.blank) begin
                  vld_q[sel_idx] <= 1'b0;
                  err_q[sel_idx] <= 1'b0;
                end else begin
                  vld_q[sel_idx] <= 1'b0;
                  err_q[sel_idx] <= 1'b1;
                end
              end
            end
          end
        end
        ST_HOLD: begin
          if (!stable) begin
            state <= ST_SETTLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_SETTLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.hex     = hex_q;
  assign bus.dp      = dp_q;
  assign bus.vld     = vld_q;
  assign bus.err     = err_q;
  assign bus.upd     = upd_q;
  assign bus.upd_idx = upd_idx_q;

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Testbench for seg_pattern_decoder (DIGITS=4, STABLE_CYCLES=4): directed scenarios
// with literal expectations, then randomized bus traffic compared every cycle
// against a behavioural model.
module tb_seg_pattern_decoder;

  localparam int DIGITS = 4;
  localparam int SC     = 4;
  localparam int HW     = 8 + DIGITS;

  localparam logic [6:0] TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk = 1'b0;
  logic rst;
  logic cmp_en = 1'b0;
  int   n_vec  = 0;
  int   n_bad  = 0;

  always #5 clk = ~clk;

  seg_pattern_decoder_if #(.DIGITS(DIGITS)) bus ();

  seg_pattern_decoder #(
    .DIGITS        (DIGITS),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Nibble for a pattern, -1 when the pattern is not a legal glyph.
  function automatic int ref_decode(input logic [6:0] y);
    for (int i = 0; i < 16; i++) begin
      if (y == TBL[i]) return i;
    end
`ifdef SEG_DECODE_ALT_GLYPH_EN
    if (y == 7'h27) return 7;
    if (y == 7'h67) return 9;
`endif
    return -1;
  endfunction

  // ---------------- behavioural model ----------------
  // hist[0] is the newest bus sample; the decoder compares hist[1] with hist[2]
  // and commits hist[1] once that comparison has held SC times in a row.
  logic [HW-1:0] hist [3];
  int            run;
  logic [3:0]    m_hex [DIGITS];
  logic [DIGITS-1:0] m_dp, m_vld, m_err;
  logic          m_upd;
  int            m_idx;

  always @(posedge clk or posedge rst) begin : model
    logic [7:0]        sg;
    logic [DIGITS-1:0] dg;
    logic [6:0]        yy;
    int                r, nz, k, nib;
    if (rst) begin
      for (int i = 0; i < 3; i++) hist[i] <= '1;
      run   <= 0;
      m_upd <= 1'b0;
      m_idx <= 0;
      for (int i = 0; i < DIGITS; i++) m_hex[i] <= 4'h0;
      m_dp  <= '0;
      m_vld <= '0;
      m_err <= '0;
    end else begin
      r = (hist[1] == hist[2]) ? run + 1 : 0;
      if (r > 1000) r = 1000;
      run   <= r;
      m_upd <= 1'b0;
      if (r == SC) begin
        sg = hist[1][HW-1:DIGITS];
        dg = hist[1][DIGITS-1:0];
        yy = ~sg[6:0];
        nz = 0;
        k  = 0;
        for (int i = 0; i < DIGITS; i++) begin
          if (!dg[i]) begin
            nz++;
            k = i;
          end
        end
        if (nz == 1) begin
          m_upd <= 1'b1;
          m_idx <= k;
          nib = ref_decode(yy);
          if (nib >= 0) begin
            m_hex[k] <= nib[3:0];
            m_vld[k] <= 1'b1;
            m_err[k] <= 1'b0;
            m_dp[k]  <= ~sg[7];
          end else if (yy == 7'h00) begin
            m_vld[k] <= 1'b0;
            m_err[k] <= 1'b0;
          end else begin
            m_vld[k] <= 1'b0;
            m_err[k] <= 1'b1;
          end
        end
      end
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= {bus.seg_n, bus.dig_n};
    end
  end

  // Every-cycle comparison, on the falling edge.
  always @(negedge clk) begin : compare
    logic [4*DIGITS-1:0] eh;
    if (cmp_en) begin
      for (int k = 0; k < DIGITS; k++) eh[4*k +: 4] = m_hex[k];
      check("hex", 32'(bus.hex), 32'(eh));
      check("dp",  32'(bus.dp),  32'(m_dp));
      check("vld", 32'(bus.vld), 32'(m_vld));
      check("err", 32'(bus.err), 32'(m_err));
      check("upd", 32'(bus.upd), 32'(m_upd));
      if (m_upd) check("upd_idx", 32'(bus.upd_idx), 32'(m_idx));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] s, input logic [DIGITS-1:0] d);
    bus.seg_n = s;
    bus.dig_n = d;
  endtask

  initial begin
    int cnt_upd;
    int kind, d, hold, gsel, nib;
    logic [6:0] y;
    logic [DIGITS-1:0] dsel;

    rst = 1'b1;
    drive(8'hFF, 4'hF);
    step(3);
    cmp_en = 1'b1;
    rst    = 1'b0;
    step(10);

    // Reset in the middle of a settle window, then glyph 0 on digit 0.
    drive(8'hC0, 4'b1110);
    step(3);
    rst = 1'b1;
    step(2);
    check("rst_hex", 32'(bus.hex), 32'h0);
    check("rst_vld", 32'(bus.vld), 32'h0);
    check("rst_upd", 32'(bus.upd), 32'h0);
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step(1);
      check("lat_upd", 32'(bus.upd), 32'(e == 7));
      if (e == 7) begin
        check("d0_idx", 32'(bus.upd_idx), 32'd0);
        check("d0_hex", 32'(bus.hex[3:0]), 32'h0);
        check("d0_vld", 32'(bus.vld[0]), 32'd1);
        check("d0_dp",  32'(bus.dp[0]), 32'd0);
      end
    end

    // Glitch: '1' for 3 cycles then '2' held on digit 1.
    cnt_upd = 0;
    drive(8'hF9, 4'b1101);
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (bus.upd) cnt_upd++;
    end
    drive(8'hA4, 4'b1101);
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (bus.upd) cnt_upd++;
    end
    check("glitch_upds", 32'(cnt_upd), 32'd1);
    check("d1_hex", 32'(bus.hex[7:4]), 32'h2);

    // Legal 5 on digit 2, then an illegal pattern.
    drive(8'h92, 4'b1011);
    step(10);
    check("d2_hex5", 32'(bus.hex[11:8]), 32'h5);
    check("d2_vld5", 32'(bus.vld[2]), 32'd1);
    drive(8'hB6, 4'b1011);
    step(10);
    check("d2_err", 32'(bus.err[2]), 32'd1);
    check("d2_vld", 32'(bus.vld[2]), 32'd0);
    check("d2_hex_kept", 32'(bus.hex[11:8]), 32'h5);

    // Two digits selected at once: nothing may commit.
    cnt_upd = 0;
    drive(8'hC0, 4'b1100);
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (bus.upd) cnt_upd++;
    end
    check("multi_upds", 32'(cnt_upd), 32'd0);
    check("multi_hex", 32'(bus.hex), 32'h0520);
    check("multi_vld", 32'(bus.vld), 32'b0011);
    check("multi_err", 32'(bus.err), 32'b0100);

    // Alternate 7 (0x27) with decimal point on digit 3.
    drive(8'h58, 4'b0111);
    step(10);
`ifdef SEG_DECODE_ALT_GLYPH_EN
    check("alt_hex", 32'(bus.hex[15:12]), 32'h7);
    check("alt_vld", 32'(bus.vld[3]), 32'd1);
    check("alt_dp",  32'(bus.dp[3]), 32'd1);
`else
    check("alt_err", 32'(bus.err[3]), 32'd1);
    check("alt_vld", 32'(bus.vld[3]), 32'd0);
`endif

    // Randomized traffic, checked by the model every cycle.
    for (int t = 0; t < 400; t++) begin
      kind = $urandom_range(9);
      if (kind < 8) begin
        d    = $urandom_range(DIGITS - 1);
        dsel = '1;
        dsel[d] = 1'b0;
      end else if (kind == 8) begin
        dsel = '1;
      end else begin
        dsel = DIGITS'($urandom);
      end
      gsel = $urandom_range(19);
      if (gsel < 12) begin
        nib = $urandom_range(15);
        y   = TBL[nib];
      end else if (gsel < 14) begin
        y = 7'h00;
      end else if (gsel < 16) begin
        y = ($urandom_range(1) == 0) ? 7'h27 : 7'h67;
      end else begin
        y = 7'($urandom);
      end
      drive({1'($urandom_range(1)), ~y}, dsel);
      hold = $urandom_range(9, 1);
      step(hold);
      if ($urandom_range(99) == 0) begin
        rst = 1'b1;
        step(2);
        rst = 1'b0;
      end
    end
    step(12);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
